// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes: substitutes `lanes` bytes per cycle of a `size`-byte state block.
// Latency: out_valid rises size/lanes edges after the accept edge; one block per size/lanes+2 cycles.
// Backpressure: result held stable in DONE until out_ready; in_ready low outside IDLE and during reset.
// Optional: define INV_SUB_BYTES_FWD_EN to add a `fwd` input selecting the forward S-box per block.
module inv_sub_bytes_iter #(
  parameter int size  = 16,
  parameter int lanes = 4
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef INV_SUB_BYTES_FWD_EN
  input  logic              fwd,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [size*8-1:0] block,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [size*8-1:0] inv_subed_block
);

  // Guard against divide-by-zero while computing derived widths for a bad lanes value.
  localparam int LANES_NZ = (lanes < 1) ? 1 : lanes;
  localparam int NCHUNK   = size / LANES_NZ;
  localparam int CW       = LANES_NZ * 8;
  localparam int CNT_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNK - 1);

  if (lanes < 1 || (size % LANES_NZ) != 0) begin : g_bad_lanes
    $error("inv_sub_bytes_iter: lanes must be >= 1 and divide size");
  end

  // FIPS-197 inverse S-box; entry x is INV_TBL[x].
  localparam logic [0:255][7:0] INV_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

`ifdef INV_SUB_BYTES_FWD_EN
  // FIPS-197 forward S-box; entry x is FWD_TBL[x].
  localparam logic [0:255][7:0] FWD_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [size*8-1:0] work_q;
  logic [CW-1:0]     chunk_in;
  logic [CW-1:0]     chunk_sub;
  logic              last_chunk;
`ifdef INV_SUB_BYTES_FWD_EN
  logic              fwd_q;
`endif

  assign last_chunk = (cnt_q == CNT_LAST);
  assign chunk_in   = work_q[int'(cnt_q)*CW +: CW];

  // One S-box lookup per lane on the chunk currently addressed by the counter.
  for (genvar l = 0; l < LANES_NZ; l++) begin : g_lane
    logic [7:0] byte_in;
    assign byte_in = chunk_in[8*l +: 8];
`ifdef INV_SUB_BYTES_FWD_EN
    assign chunk_sub[8*l +: 8] = fwd_q ? FWD_TBL[byte_in] : INV_TBL[byte_in];
`else
    assign chunk_sub[8*l +: 8] = INV_TBL[byte_in];
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs; in_ready is forced low while reset is asserted.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = rst_n;
        if (in_valid && rst_n) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (last_chunk) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture on accept, then rewrite one chunk per BUSY cycle in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q <= '0;
      cnt_q  <= '0;
`ifdef INV_SUB_BYTES_FWD_EN
      fwd_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            work_q <= block;
            cnt_q  <= '0;
`ifdef INV_SUB_BYTES_FWD_EN
            fwd_q  <= fwd;
`endif
          end
        end
        BUSY: begin
          work_q[int'(cnt_q)*CW +: CW] <= chunk_sub;
          cnt_q <= last_chunk ? '0 : cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Only a completed block is ever visible on the output bus.
  assign inv_subed_block = (state_q == DONE) ? work_q : '0;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Directed bench for inv_sub_bytes_iter with lanes=4 (main), lanes=1 and lanes=16 instances.
module tb_inv_sub_bytes_iter;

  logic clk;
  logic rst_n;

  logic [2:0]        in_valid_v;
  logic [2:0]        out_ready_v;
  logic [2:0][127:0] block_v;
`ifdef INV_SUB_BYTES_FWD_EN
  logic [2:0]        fwd_v;
`endif

  logic rdy0, rdy1, rdy2;
  logic vld0, vld1, vld2;
  logic [127:0] obk0, obk1, obk2;
  logic [2:0]        in_ready_v;
  logic [2:0]        out_valid_v;
  logic [2:0][127:0] out_v;

  assign in_ready_v  = {rdy2, rdy1, rdy0};
  assign out_valid_v = {vld2, vld1, vld0};
  assign out_v       = {obk2, obk1, obk0};

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  inv_sub_bytes_iter #(.size(16), .lanes(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
`ifdef INV_SUB_BYTES_FWD_EN
    .fwd(fwd_v[0]),
`endif
    .in_valid(in_valid_v[0]), .in_ready(rdy0), .block(block_v[0]),
    .out_valid(vld0), .out_ready(out_ready_v[0]), .inv_subed_block(obk0)
  );

  inv_sub_bytes_iter #(.size(16), .lanes(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
`ifdef INV_SUB_BYTES_FWD_EN
    .fwd(fwd_v[1]),
`endif
    .in_valid(in_valid_v[1]), .in_ready(rdy1), .block(block_v[1]),
    .out_valid(vld1), .out_ready(out_ready_v[1]), .inv_subed_block(obk1)
  );

  inv_sub_bytes_iter #(.size(16), .lanes(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
`ifdef INV_SUB_BYTES_FWD_EN
    .fwd(fwd_v[2]),
`endif
    .in_valid(in_valid_v[2]), .in_ready(rdy2), .block(block_v[2]),
    .out_valid(vld2), .out_ready(out_ready_v[2]), .inv_subed_block(obk2)
  );

  typedef struct packed {
    logic [127:0] blk;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Push one block into instance k and follow it through to the output handshake.
  task automatic run_block(input int k, input logic [127:0] blk, input logic [127:0] exp,
                           input int lat, input logic fwd_b, input bit mutate, input int hold);
    int n;
    n = 0;
    while (!in_ready_v[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_idle", 128'(in_ready_v[k]), 128'd1);
    in_valid_v[k]  = 1'b1;
    block_v[k]     = blk;
    out_ready_v[k] = (hold == 0);
`ifdef INV_SUB_BYTES_FWD_EN
    fwd_v[k] = fwd_b;
`else
    if (fwd_b) $display("note: fwd request ignored in inverse-only build");
`endif
    @(posedge clk);
    @(negedge clk);
    in_valid_v[k] = 1'b0;
    if (mutate) begin
      block_v[k] = ~blk;
`ifdef INV_SUB_BYTES_FWD_EN
      fwd_v[k] = ~fwd_b;
`endif
    end
    check("in_ready_busy", 128'(in_ready_v[k]), 128'd0);
    n = 0;
    while (!out_valid_v[k] && n < 40) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check("latency", 128'(n), 128'(lat));
    check("data", out_v[k], exp);
    for (int h = 0; h < hold; h++) begin
      in_valid_v[k] = 1'b1;
      block_v[k]    = ~blk;
      @(posedge clk);
      @(negedge clk);
      check("hold_data", out_v[k], exp);
      check("hold_valid", 128'(out_valid_v[k]), 128'd1);
      check("hold_in_ready", 128'(in_ready_v[k]), 128'd0);
    end
    in_valid_v[k]  = 1'b0;
    out_ready_v[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("out_valid_after", 128'(out_valid_v[k]), 128'd0);
    check("in_ready_after", 128'(in_ready_v[k]), 128'd1);
  endtask

  localparam logic [127:0] TV_IN  = 128'h63cab7040953d051cd60e0e7ba70e18c;
  localparam logic [127:0] TV_OUT = 128'h00102030405060708090a0b0c0d0e0f0;

  initial begin
    vecs[0] = '{blk: TV_IN, exp: TV_OUT};
    vecs[1] = '{blk: 128'h0, exp: {16{8'h52}}};
    vecs[2] = '{blk: {16{8'hff}}, exp: {16{8'h7d}}};
    vecs[3] = '{blk: 128'h000102030405060708090a0b0c0d0e0f,
                exp: 128'h52096ad53036a538bf40a39e81f3d7fb};
    vecs[4] = '{blk: {16{8'h63}}, exp: 128'h0};

    in_valid_v  = '0;
    out_ready_v = '0;
    block_v     = '0;
`ifdef INV_SUB_BYTES_FWD_EN
    fwd_v       = '0;
`endif
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    for (int k = 0; k < 3; k++) begin
      check("rst_in_ready", 128'(in_ready_v[k]), 128'd0);
      check("rst_out_valid", 128'(out_valid_v[k]), 128'd0);
      check("rst_out", out_v[k], 128'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rel_in_ready", 128'(in_ready_v[k]), 128'd1);
    end
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_block(0, vecs[i].blk, vecs[i].exp, 4, 1'b0, 1'b0, 0);
    end

    // Backpressure in DONE with a competing input, then the next block.
    run_block(0, TV_IN, TV_OUT, 4, 1'b0, 1'b0, 10);
    run_block(0, 128'h0, {16{8'h52}}, 4, 1'b0, 1'b0, 0);

    // Block changes right after accept on all three lane configurations.
    run_block(0, TV_IN, TV_OUT, 4, 1'b0, 1'b1, 0);
    run_block(1, TV_IN, TV_OUT, 16, 1'b0, 1'b1, 0);
    run_block(2, TV_IN, TV_OUT, 1, 1'b0, 1'b1, 2);
    run_block(1, vecs[3].blk, vecs[3].exp, 16, 1'b0, 1'b0, 0);

    // Async reset after two chunks of a block.
    in_valid_v[0]  = 1'b1;
    block_v[0]     = TV_IN;
    out_ready_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 128'(out_valid_v[0]), 128'd0);
    check("mid_rst_out", out_v[0], 128'd0);
    check("mid_rst_in_ready", 128'(in_ready_v[0]), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rel_in_ready", 128'(in_ready_v[0]), 128'd1);
    check("mid_rel_out_valid", 128'(out_valid_v[0]), 128'd0);
    @(negedge clk);
    run_block(0, {16{8'hff}}, {16{8'h7d}}, 4, 1'b0, 1'b0, 0);

`ifdef INV_SUB_BYTES_FWD_EN
    run_block(0, TV_OUT, TV_IN, 4, 1'b1, 1'b0, 0);
    run_block(0, TV_IN, TV_OUT, 4, 1'b0, 1'b0, 0);
    run_block(2, TV_OUT, TV_IN, 1, 1'b1, 1'b1, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/inv_sub_bytes_iter.md
Name: inv_sub_bytes_iter

Overview:
- Iterative AES InvSubBytes engine; the decrypt-side counterpart of the combinational sub_bytes stage.
- Accepts one `size`-byte state block over a valid/ready handshake.
- Substitutes `lanes` bytes per cycle through inverse S-box ROMs, then presents the result over a second valid/ready handshake.
- Sits between the InvShiftRows and AddRoundKey stages of the decryption datapath.

Parameters:
- size, 16, block width in bytes; block bus is size*8 bits.
- lanes, 4, bytes substituted per cycle; must divide size; elaboration error otherwise.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  block holds a valid state.
- in_ready  output  1  engine can accept a block.
- block  input  size*8  state in; byte i = block[8i+7:8i].
- out_valid  output  1  inv_subed_block is valid.
- out_ready  input  1  consumer accepts result.
- inv_subed_block  output  size*8  substituted state; byte i = InvSbox(input byte i).

Behaviour:
- Reset, async on rst_n low, regardless of state:
  - state=IDLE, chunk counter=0, working register=0.
  - in_ready=0 while rst_n low, 1 in first IDLE cycle after release.
  - out_valid=0, inv_subed_block=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On edge with in_valid && in_ready: capture block into working register, counter=0, go to BUSY.
- BUSY:
  - in_ready=0, out_valid=0.
  - Each edge replaces bytes [counter*lanes .. counter*lanes+lanes-1] of the working register with their InvSbox values, then increments counter.
  - When the chunk just processed is the last (counter == size/lanes-1): counter returns to 0, go to DONE.
- DONE:
  - out_valid=1, inv_subed_block = working register, held stable while out_ready=0.
  - On edge with out_ready=1: go to IDLE.
  - in_ready=0 in DONE; no overlap of input and output handshakes.
- Latency: accept edge at T; out_valid high after edge T+size/lanes (T+4 by default).
- Throughput: one block per size/lanes+2 cycles minimum.
- block is sampled only on the accept edge; later changes on block are ignored.
- Counter width is clog2(size/lanes), minimum 1 bit; wraps exactly at size/lanes-1.
- Inverse S-box: FIPS-197 table, e.g. 63->00, 00->52, ff->7d.
- Pure function of the captured data; no other stored state.
- in_valid during BUSY/DONE is ignored (not captured).
- out_ready in IDLE/BUSY has no effect.
- Reset mid-BUSY or mid-DONE discards the block; no partial output is ever presented.

Optional Feature:
- Macro INV_SUB_BYTES_FWD_EN.
- When defined:
  - Adds input port fwd (1 bit), sampled on the accept edge alongside block.
  - fwd=1 selects the forward S-box for the whole block (63 for 00); fwd=0 selects the inverse S-box.
  - Both ROMs are instantiated per lane; the selection is registered with the block.
- When undefined: no fwd port, inverse S-box only, forward ROMs not instantiated.

Test Plan:
- Reset then single block: block=128'h63cab7040953d051cd60e0e7ba70e18c, out_ready=1 -> out_valid rises 4 cycles after accept, inv_subed_block=128'h00102030405060708090a0b0c0d0e0f0, then IDLE with in_ready=1.
- All-zero and all-ones blocks -> 128'h5252...52 and 128'h7d7d...7d respectively.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while driving new in_valid/block -> output stable, in_ready=0, new block not captured; releasing out_ready completes handshake, then next block is processed correctly.
- Async reset asserted mid-BUSY (after 2 chunks) -> immediately out_valid=0, output=0; after release in_ready=1, a fresh block yields correct result with full 4-cycle latency.
- Change block on the edge after accept -> result reflects the accepted value only; repeat with lanes=1 and lanes=16 (latency 16 and 1).
- With INV_SUB_BYTES_FWD_EN: fwd=1, block=128'h00102030405060708090a0b0c0d0e0f0 -> 128'h63cab7040953d051cd60e0e7ba70e18c; fwd=0 on that output round-trips to the original.
